// File: rtl/rf_wb_arbiter.sv
// Writeback-port arbiter: shares the register-file write port between a
// buffered ALU source (2-entry queue) and a priority load source, with a
// starvation limit that force-grants the ALU queue head.
module rf_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        A_valid,
  input  logic [4:0]  A_addr,
  input  logic [31:0] A_data,
  output logic        A_ready,
  input  logic        L_valid,
  input  logic [4:0]  L_addr,
  input  logic [31:0] L_data,
  output logic        L_ready,
  output logic        Write,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic        busy
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NW    = 2;

  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     mem_q [DEPTH];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [NW-1:0] count_q;
  logic [NW-1:0] count_d;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          write_q;
  logic [AW-1:0] wr_q;
  logic [DW-1:0] wd_q;

  logic          empty;
  logic          full;
  logic          forced;
  logic          push;
  logic          grant_alu;
  logic          grant_load;
  logic          grant_any;
  logic          gnt_live;
  wb_entry_t     head;
  wb_entry_t     gnt;

  // Arbitration, queue handshake and starvation-counter next state.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    head       = mem_q[rd_ptr_q];
    forced     = (starve_q == WAIT_LIM) && !empty;
    grant_alu  = !empty && (forced || !L_valid);
    grant_load = L_valid && !forced;
    grant_any  = grant_alu || grant_load;
    A_ready    = Reset_n && !full;
    L_ready    = Reset_n && grant_load;
    push       = A_valid && A_ready;
    busy       = !empty;
    gnt        = grant_alu ? head : wb_entry_t'{addr: L_addr, data: L_data};
    gnt_live   = grant_any && (gnt.addr != '0);
    count_d    = count_q + NW'(push) - NW'(grant_alu);
    starve_d   = starve_q;
    if (grant_alu || empty) begin
      starve_d = '0;
    end else if (grant_load && (starve_q < WAIT_LIM)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // ALU queue storage, pointers and starvation counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wb_entry_t'{addr: A_addr, data: A_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (grant_alu) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Registered write port; r0 grants and idle cycles leave WR/WD untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      write_q <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
    end else begin
      write_q <= gnt_live;
      if (gnt_live) begin
        wr_q <= gnt.addr;
        wd_q <= gnt.data;
      end
    end
  end

  assign Write = write_q;
  assign WR    = wr_q;
  assign WD    = wd_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback-port arbiter for the 32x32 register file. The register file has a single write port (Write, WR, WD), which this block shares between two writeback sources. The ALU source is buffered in a 2-entry queue. The load source is unbuffered and has priority, bounded by a starvation limit that protects the ALU. The block drives the register-file write port from registers, so each write is presented for exactly one Clk cycle.

## Interface
- MAX_WAIT, default 3: cycles the ALU queue head may be denied before it is force-granted. Legal range 1..15.
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- A_valid  in  1  ALU writeback request.
- A_addr  in  5  ALU destination register.
- A_data  in  32  ALU result.
- A_ready  out  1  ALU queue can accept an entry (queue not full).
- L_valid  in  1  load writeback request.
- L_addr  in  5  load destination register.
- L_data  in  32  load data.
- L_ready  out  1  load granted this cycle (combinational).
- Write  out  1  register-file write enable, registered.
- WR  out  5  register-file write address, registered.
- WD  out  32  register-file write data, registered.
- busy  out  1  ALU queue non-empty.

## Operation
- ALU queue: 2-entry FIFO of {addr, data}.
  - Push when A_valid & A_ready.
  - A_ready = !full. When full, no push, even if a pop occurs in the same cycle.
- Arbitration, evaluated every cycle over two candidates: load (L_valid) and ALU queue head (non-empty).
  - If starve_cnt == MAX_WAIT and the queue is non-empty: grant ALU head.
  - Else if L_valid: grant load.
  - Else if the queue is non-empty: grant ALU head.
  - Else: no grant.
- L_ready = grant_load. A load handshake completes when L_valid & L_ready.
- ALU grant pops the queue head. Push and pop in the same cycle are legal when the queue is not full.
- starve_cnt (4 bits):
  - Reset to 0 on ALU grant or when the queue is empty.
  - Incremented when the queue is non-empty and load is granted.
  - Saturates at MAX_WAIT.
- Output register update on a grant:
  - Write <= (granted addr != 0).
  - WR <= granted addr and WD <= granted data, only if addr != 0. Otherwise WR and WD hold.
- With no grant: Write <= 0; WR and WD hold their previous values.
- Writes to r0 complete the handshake (pop or L_ready) and count as a grant for starve_cnt, but never assert Write.
- Arbitration ignores addresses. If both sources target the same register, the register file receives both writes in grant order.

## Timing
- Reset (Reset_n low, asynchronous):
  - Write = 0, WR = 0, WD = 0.
  - Queue empty, starve_cnt = 0.
  - A_ready = 0 and L_ready = 0 while Reset_n is low.
  - A_ready = 1 from the first cycle after release.
- Reset mid-operation: queued entries and in-flight grants are discarded. No Write pulse follows.
- Load latency: handshake in cycle t -> Write/WR/WD valid in cycle t+1.
- ALU latency:
  - Push in cycle t -> earliest grant in t+1 -> Write in t+2.
  - Each load-granted cycle adds one cycle of delay, up to MAX_WAIT.
- Worst-case ALU head wait under continuous L_valid: MAX_WAIT cycles, then forced grant. In the forced cycle L_ready = 0.
- Throughput: one write per cycle, never more. Back-to-back grants produce consecutive Write-high cycles.
- Write is high for exactly one cycle per non-r0 grant.

## Test plan
- Reset, then a single ALU push {addr 5, data 0xDEADBEEF} in cycle 1 -> Write=1, WR=5, WD=0xDEADBEEF in cycle 3 only; busy high in cycle 2 only.
- Load {7, 0x1234} and queued ALU head {3, 0xAA} valid in the same cycle with starve_cnt=0 -> load written first; ALU written on the next cycle; L_ready=1 only in the first cycle.
- L_valid held high for 10 cycles with one ALU entry queued, MAX_WAIT=3 -> ALU head granted on its 4th waiting cycle; L_ready=0 in that cycle only; all 10 loads eventually written in order.
- Three ALU pushes in consecutive cycles while L_valid is held high -> A_ready drops to 0 when the queue is full; the third push stalls until the first forced pop; no entry lost or duplicated.
- Load to r0 with data 0xFFFFFFFF following a write to r9 -> handshake completes; Write=0 next cycle; WR stays 9 and WD holds.
- Reset_n pulsed low asynchronously with 2 queued entries mid-cycle -> Write, WR and WD go to 0 immediately; no Write pulse after release; A_ready=1 on the first cycle after release.
